// File: rtl/obstacle_spawner.sv
// Obstacle spawner: three-slot scrolling obstacle manager for a runner game.
// Ports: clk, reset (async high), frame_tick, halt, restart, random[4:0],
//   speed[2:0] in; obs_valid[2:0], obs_x[32:0], obs_type[5:0],
//   spawn_pulse, running out (all registered).
module obstacle_spawner #(
  parameter int unsigned SPAWN_X = 640,
  parameter int unsigned MIN_GAP = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        halt,
  input  logic        restart,
  input  logic [4:0]  random,
  input  logic [2:0]  speed,
  output logic [2:0]  obs_valid,
  output logic [32:0] obs_x,
  output logic [5:0]  obs_type,
  output logic        spawn_pulse,
  output logic        running
);

  typedef enum logic {
    HALTED = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [10:0] SpawnX = 11'(SPAWN_X);
  localparam logic [7:0]  MinGap = 8'(MIN_GAP);

  // Reset asserts at once but releases two edges after the pin drops.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_i;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= rst_sync_d;
  end

  assign rst_i = rst_sync_q[1];

  state_t      state_q, state_d;
  logic [2:0]  valid_q, valid_d;
  logic [10:0] x_q [3];
  logic [10:0] x_d [3];
  logic [1:0]  type_q [3];
  logic [1:0]  type_d [3];
  logic [7:0]  gap_q, gap_d;
  logic        pulse_q, pulse_d;
  logic        run_q, run_d;

  logic        tick_ok;
  logic        free_found;
  logic [1:0]  free_idx;
  logic [10:0] spd_ext;
  logic [1:0]  new_type;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    x_d     = x_q;
    type_d  = type_q;
    gap_d   = gap_q;
    pulse_d = 1'b0;
    spd_ext = {8'd0, speed};
    new_type = (random[1:0] == 2'd3) ? 2'd0 : random[1:0];
    tick_ok = (state_q == RUN) && frame_tick && !halt && !restart;

    // Free slot is chosen from the pre-tick valid bits so a slot
    // that drops off this tick is not reused until the next one.
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end

    if (restart) begin
      state_d = RUN;
      valid_d = 3'b000;
      gap_d   = MinGap;
      for (int i = 0; i < 3; i++) begin
        x_d[i]    = 11'd0;
        type_d[i] = 2'd0;
      end
    end else if (state_q == RUN && halt) begin
      state_d = HALTED;
    end else if (tick_ok) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_q[i]) begin
          if (x_q[i] >= spd_ext) begin
            x_d[i] = x_q[i] - spd_ext;
          end else begin
            valid_d[i] = 1'b0;
            x_d[i]     = 11'd0;
          end
        end
      end
      if (gap_q != 8'd0) begin
        gap_d = gap_q - 8'd1;
      end else begin
        gap_d = MinGap + {3'd0, random};
        if (free_found) begin
          valid_d[free_idx] = 1'b1;
          x_d[free_idx]     = SpawnX;
          type_d[free_idx]  = new_type;
          pulse_d           = 1'b1;
        end
      end
    end

    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HALTED;
      valid_q <= 3'b000;
      gap_q   <= MinGap;
      pulse_q <= 1'b0;
      run_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        x_q[i]    <= 11'd0;
        type_q[i] <= 2'd0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      run_q   <= run_d;
      for (int i = 0; i < 3; i++) begin
        x_q[i]    <= x_d[i];
        type_q[i] <= type_d[i];
      end
    end
  end

  always_comb begin
    obs_x    = '0;
    obs_type = '0;
    for (int i = 0; i < 3; i++) begin
      obs_x[11*i +: 11]  = x_q[i];
      obs_type[2*i +: 2] = type_q[i];
    end
  end

  assign obs_valid   = valid_q;
  assign spawn_pulse = pulse_q;
  assign running     = run_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: directed scenarios plus
// randomized traffic compared against a slot-level reference model.
module tb_obstacle_spawner;

  localparam int SPAWN_X = 640;
  localparam int MIN_GAP = 40;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        halt;
  logic        restart;
  logic [4:0]  random;
  logic [2:0]  speed;
  logic [2:0]  obs_valid;
  logic [32:0] obs_x;
  logic [5:0]  obs_type;
  logic        spawn_pulse;
  logic        running;

  obstacle_spawner #(
    .SPAWN_X(SPAWN_X),
    .MIN_GAP(MIN_GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .halt(halt),
    .restart(restart),
    .random(random),
    .speed(speed),
    .obs_valid(obs_valid),
    .obs_x(obs_x),
    .obs_type(obs_type),
    .spawn_pulse(spawn_pulse),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit m_valid [3];
  int m_x [3];
  int m_type [3];
  int m_cnt;
  bit m_run;
  bit m_pulse;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0; m_x[i] = 0; m_type[i] = 0;
    end
    m_cnt = MIN_GAP; m_run = 0; m_pulse = 0;
  endtask

  function automatic int slot_x(input int i);
    logic [32:0] v;
    v = obs_x;
    return int'(v[11*i +: 11]);
  endfunction

  function automatic int slot_t(input int i);
    logic [5:0] v;
    v = obs_type;
    return int'(v[2*i +: 2]);
  endfunction

  task automatic model_step(input bit ft, input bit h, input bit rs,
                            input int rnd, input int spd);
    int fr;
    m_pulse = 0;
    if (rs) begin
      m_run = 1; m_cnt = MIN_GAP;
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0; m_x[i] = 0; m_type[i] = 0;
      end
    end else if (m_run && h) begin
      m_run = 0;
    end else if (m_run && ft) begin
      fr = -1;
      for (int i = 2; i >= 0; i--) if (!m_valid[i]) fr = i;
      for (int i = 0; i < 3; i++) begin
        if (m_valid[i]) begin
          if (m_x[i] >= spd) m_x[i] -= spd;
          else begin m_valid[i] = 0; m_x[i] = 0; end
        end
      end
      if (m_cnt != 0) m_cnt--;
      else begin
        m_cnt = MIN_GAP + rnd;
        if (fr >= 0) begin
          m_valid[fr] = 1;
          m_x[fr] = SPAWN_X;
          m_type[fr] = ((rnd % 4) == 3) ? 0 : (rnd % 4);
          m_pulse = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] ev;
    for (int i = 0; i < 3; i++) ev[i] = m_valid[i];
    chk("obs_valid", 32'(obs_valid), 32'(ev));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("obs_x[%0d]", i), 32'(slot_x(i)), 32'(m_x[i]));
      if (m_valid[i])
        chk($sformatf("obs_type[%0d]", i), 32'(slot_t(i)), 32'(m_type[i]));
    end
    chk("spawn_pulse", 32'(spawn_pulse), 32'(m_pulse));
    chk("running", 32'(running), 32'(m_run));
  endtask

  task automatic step(input bit ft, input bit h, input bit rs,
                      input int rnd, input int spd);
    @(negedge clk);
    frame_tick = ft; halt = h; restart = rs;
    random = 5'(rnd); speed = 3'(spd);
    @(posedge clk);
    #1;
    model_step(ft, h, rs, rnd, spd);
    compare_all();
  endtask

  int held [3];
  int spd_r;

  initial begin
    reset = 1'b1; frame_tick = 0; halt = 0; restart = 0;
    random = 0; speed = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(obs_valid), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_pulse", 32'(spawn_pulse), 0);
    chk("reset_x", 32'(obs_x), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step(0, 0, 0, 0, 2);

    // First spawn after 40 countdown ticks, reload 46.
    step(0, 0, 1, 0, 2);
    chk("restart_running", 32'(running), 1);
    repeat (40) step(1, 0, 0, int'($urandom_range(0, 31)), 2);
    chk("no_early_spawn", 32'(obs_valid), 0);
    step(1, 0, 0, 6, 2);
    chk("spawn0_valid", 32'(obs_valid), 1);
    chk("spawn0_x", 32'(slot_x(0)), 640);
    chk("spawn0_type", 32'(slot_t(0)), 2);
    chk("spawn0_pulse", 32'(spawn_pulse), 1);
    step(1, 0, 0, 0, 2);
    chk("pulse_one_cycle", 32'(spawn_pulse), 0);
    repeat (45) step(1, 0, 0, int'($urandom_range(0, 31)), 2);
    chk("reload46_wait", 32'(obs_valid), 1);
    step(1, 0, 0, 1, 2);
    chk("reload46_spawn", 32'(spawn_pulse), 1);
    chk("reload46_slot1", 32'(obs_valid), 3);

    // Freeze under halt, then restart.
    step(0, 1, 0, 0, 2);
    chk("halt_running", 32'(running), 0);
    for (int i = 0; i < 3; i++) held[i] = slot_x(i);
    repeat (10) step(1, 1, 0, int'($urandom_range(0, 31)), 5);
    for (int i = 0; i < 3; i++)
      chk("halt_frozen", 32'(slot_x(i)), 32'(held[i]));
    chk("halt_valid_kept", 32'(obs_valid), 3);
    step(0, 0, 1, 0, 2);
    chk("restart_clear", 32'(obs_valid), 0);
    chk("restart_run", 32'(running), 1);

    // Halt and restart together: restart wins, counter at 40.
    repeat (5) step(1, 0, 0, 0, 2);
    step(1, 1, 1, 0, 2);
    chk("both_running", 32'(running), 1);
    chk("both_clear", 32'(obs_valid), 0);
    repeat (40) step(1, 0, 0, 0, 2);
    chk("both_nospawn", 32'(spawn_pulse), 0);
    step(1, 0, 0, 0, 2);
    chk("both_spawn41", 32'(spawn_pulse), 1);

    // Type 3 maps to 0; speed 0 freezes while spawning continues.
    step(0, 0, 1, 0, 0);
    repeat (40) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 3, 0);
    chk("type3_map", 32'(slot_t(0)), 0);
    chk("type3_valid", 32'(obs_valid), 1);
    repeat (100) step(1, 0, 0, 0, 0);
    chk("spd0_full", 32'(obs_valid), 7);
    chk("spd0_x0", 32'(slot_x(0)), 640);

    // Randomized traffic against the model.
    spd_r = 2;
    step(0, 0, 1, 0, spd_r);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) spd_r = int'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0,
           $urandom_range(0, 299) == 0 || (!m_run && $urandom_range(0, 19) == 0),
           int'($urandom_range(0, 31)), spd_r);
    end

    // Asynchronous reset between edges while running.
    step(0, 0, 1, 0, 1);
    repeat (60) step(1, 0, 0, int'($urandom_range(0, 31)), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(obs_valid), 0);
    chk("async_x", 32'(obs_x), 0);
    chk("async_type", 32'(obs_type), 0);
    chk("async_pulse", 32'(spawn_pulse), 0);
    chk("async_running", 32'(running), 0);
    #1 reset = 1'b0;
    model_reset();
    repeat (3) step(0, 0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 1);
    chk("post_reset_halted", 32'(running), 0);
    step(0, 0, 1, 0, 1);
    chk("post_reset_restart", 32'(running), 1);
    repeat (50) step(1, 0, 0, int'($urandom_range(0, 31)), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 Parameter SPAWN_X, default 640: x coordinate loaded into a newly spawned obstacle (first column right of the visible area).
REQ-002 Parameter MIN_GAP, default 40: minimum frames between spawns; MIN_GAP+31 SHALL be <= 255.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-006 halt  input  1  collision/freeze request, level.
REQ-007 restart  input  1  synchronous new-game request, level.
REQ-008 random  input  5  free-running random value, sampled only at spawn.
REQ-009 speed  input  3  pixels moved per frame; 0 means no motion.
REQ-010 obs_valid  output  3  per-slot active flag, slot i on bit i.
REQ-011 obs_x  output  33  per-slot left-edge x, 11 bits per slot, slot i on bits [11i+10:11i].
REQ-012 obs_type  output  6  per-slot sprite type, 2 bits per slot: 0 cactus1, 1 cactus2, 2 cactus3.
REQ-013 spawn_pulse  output  1  one-cycle high on the cycle a spawn is committed.
REQ-014 running  output  1  high while state is RUN.

Function
REQ-015 The block SHALL implement two states, HALTED and RUN.
REQ-016 In HALTED, restart SHALL cause a move to RUN on the next edge, clearing all slots and loading the gap counter with MIN_GAP.
REQ-017 In RUN, restart SHALL clear all slots, reload the gap counter with MIN_GAP, and keep the state at RUN.
REQ-018 In RUN, halt with restart low SHALL cause a move to HALTED, with slot contents frozen and held.
REQ-019 When halt and restart are asserted in the same cycle, restart SHALL take priority.
REQ-020 frame_tick SHALL be ignored in HALTED, and on any cycle where halt or restart is high.
REQ-021 On a RUN frame_tick, each valid slot SHALL update as follows: if x >= speed then x <= x - speed, else valid <= 0 and x <= 0.
REQ-022 On a RUN frame_tick, the 8-bit gap counter SHALL decrement if it is nonzero.
REQ-023 When the counter is 0 on a RUN frame_tick, a spawn attempt SHALL occur: the counter reloads with MIN_GAP + random[4:0] (8-bit add, no overflow by REQ-002).
REQ-024 A spawn attempt SHALL target the lowest-index slot whose valid bit was 0 before the tick; a slot freed on the same tick SHALL NOT be reused on that tick.
REQ-025 The spawned slot SHALL load valid=1 and x=SPAWN_X, and SHALL NOT be moved on its spawn tick.
REQ-026 The spawned type SHALL be random[1:0], except that value 3 SHALL map to 0.
REQ-027 spawn_pulse SHALL be high for exactly the cycle after a committed spawn tick.
REQ-028 If no slot is free, the attempt SHALL be dropped with no slot change and no spawn_pulse; the counter still reloads.
REQ-029 All outputs SHALL be registered, with latency of 1 clk from frame_tick to updated obs_valid/obs_x/obs_type.
REQ-030 speed changes SHALL take effect on the next frame_tick; a value of 0 SHALL freeze positions while spawning continues.
REQ-031 x arithmetic SHALL be 11-bit unsigned with no wrap, guaranteed by the REQ-021 underflow check.

Reset
REQ-032 reset high SHALL immediately (asynchronously) force state HALTED, obs_valid=0, obs_x=0, obs_type=0, spawn_pulse=0, running=0, and gap counter=MIN_GAP.
REQ-033 Reset asserted mid-RUN SHALL discard all slots; after release the block SHALL stay HALTED until restart.
REQ-034 Release of reset SHALL be synchronous to clk at the block boundary (two-flop release internally).

Verification
REQ-035 Scenario: reset, restart 1 cycle, speed=2, 40 ticks -> counter reaches 0 on tick 41, where random=5'b00110 causes slot0 valid, x=640, type=2, spawn_pulse once, counter reloaded to 46.
REQ-036 Scenario: slot0 x=3, speed=4, tick -> slot0 valid=0, x=0; a spawn attempt on the same tick with slots 1,2 full is dropped with no spawn_pulse.
REQ-037 Scenario: all slots at x=500, halt asserted, 10 ticks -> positions unchanged and running=0; then restart -> obs_valid=0, running=1.
REQ-038 Scenario: halt and restart high in the same cycle while RUN -> state RUN, slots cleared, counter=40.
REQ-039 Scenario: random[1:0]=3 at spawn -> type=0; speed=0 for 100 ticks -> x stays 640 and further spawns fill slots 1 and 2.
REQ-040 Scenario: reset pulsed asynchronously between clk edges while RUN -> outputs zero before the next edge, and state is HALTED after release.
